// File: rtl/audio_sample_serializer.sv
// audio_sample_serializer
//   Consumer end of the wave-generator sample stream. Samples arrive over a
//   valid/ready handshake, wait in a small FIFO, and are shifted out MSB-first
//   as a standard I2S stream (bclk, lrck, sdata). The synth is mono, so each
//   frame carries the same sample in the left and the right slot.
//
//   Build option UNDERRUN_HOLD_EN:
//     defined   -> a frame that starts with an empty FIFO repeats the last sample
//     undefined -> a frame that starts with an empty FIFO sends silence (zero)
//   The underrun pulse behaves the same in both builds.
//
//   The FIFO keeps running while en=0; only the bit-clock/frame logic is parked.
//   The frame word is cleared while en=0, so the first frame after enabling
//   (like the first frame after reset) is silent and its leading bit is 0.
module audio_sample_serializer #(
    parameter int SAMPLE_W   = 32,   // bits per channel slot
    parameter int FIFO_DEPTH = 4,    // power of 2, >= 2
    parameter int BCLK_DIV   = 4     // clk cycles per bclk half-period, >= 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrck,
    output logic                sdata,
    output logic                underrun
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SAMPLE_W);
    localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SAMPLE_W - 1);
    localparam logic [BIT_W-1:0] SLOT_FIRST = BIT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(SAMPLE_W - 1);

    // Word bit carried at frame position n (n != 0). The I2S one-bit delay
    // means position n carries slot bit (n-1) mod SAMPLE_W counted from the
    // MSB; position SAMPLE_W therefore carries the left-slot LSB.
    function automatic logic [IDX_W-1:0] slot_bit_index(input logic [BIT_W-1:0] n);
        logic [BIT_W-1:0] off;
        if (n > SLOT_FIRST) begin
            off = n - SLOT_FIRST - BIT_W'(1);
        end else begin
            off = n - BIT_W'(1);
        end
        return IDX_MSB - off[IDX_W-1:0];
    endfunction

    // ---------------- FIFO state ----------------
    logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                sample_ready_r;

    // ---------------- serializer state ----------------
    logic [DIV_W-1:0]    div_cnt_r;
    logic                bclk_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic                lrck_r;
    logic                sdata_r;
    logic                underrun_r;
    logic [SAMPLE_W-1:0] word_r;

    // ---------------- combinational helpers ----------------
    logic                div_term_s;
    logic                fall_evt_s;
    logic [BIT_W-1:0]    bit_cnt_nxt_s;
    logic                frame_start_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic                sdata_nxt_s;
    logic [SAMPLE_W-1:0] underrun_word_s;
    logic [SAMPLE_W-1:0] load_word_s;

    // Bit-clock divider terminal count, falling-edge event and next frame position.
    always_comb begin
        div_term_s = (div_cnt_r == DIV_LAST);
        fall_evt_s = en & div_term_s & bclk_r;
        if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_nxt_s = BIT_W'(0);
        end else begin
            bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
        end
        frame_start_s = fall_evt_s & (bit_cnt_nxt_s == BIT_W'(0));
    end

    // FIFO handshake: push against the registered ready, pop at each frame start.
    always_comb begin
        fifo_empty_s = (count_r == CNT_W'(0));
        push_s       = sample_valid & sample_ready_r;
        pop_s        = frame_start_s & ~fifo_empty_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next serial bit and the word to load at the coming frame start.
    always_comb begin
        if (bit_cnt_nxt_s == BIT_W'(0)) begin
            // Position 0 still carries the LSB of the word that just finished.
            sdata_nxt_s = word_r[0];
        end else begin
            sdata_nxt_s = word_r[slot_bit_index(bit_cnt_nxt_s)];
        end
`ifdef UNDERRUN_HOLD_EN
        underrun_word_s = word_r;
`else
        underrun_word_s = {SAMPLE_W{1'b0}};
`endif
        if (pop_s) begin
            load_word_s = mem_r[rd_ptr_r];
        end else begin
            load_word_s = underrun_word_s;
        end
    end

    // Sample FIFO storage, pointers, occupancy and registered ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {SAMPLE_W{1'b0}};
            end
            wr_ptr_r       <= PTR_W'(0);
            rd_ptr_r       <= PTR_W'(0);
            count_r        <= CNT_W'(0);
            sample_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sample_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r        <= count_nxt_s;
            sample_ready_r <= (count_nxt_s != CNT_FULL);
        end
    end

    // Bit clock, frame position, I2S outputs and frame word; all parked while en=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r  <= DIV_W'(0);
            bclk_r     <= 1'b0;
            bit_cnt_r  <= BIT_W'(0);
            lrck_r     <= 1'b0;
            sdata_r    <= 1'b0;
            underrun_r <= 1'b0;
            word_r     <= {SAMPLE_W{1'b0}};
        end else if (!en) begin
            div_cnt_r  <= DIV_W'(0);
            bclk_r     <= 1'b0;
            bit_cnt_r  <= BIT_W'(0);
            lrck_r     <= 1'b0;
            sdata_r    <= 1'b0;
            underrun_r <= 1'b0;
            word_r     <= {SAMPLE_W{1'b0}};
        end else begin
            if (div_term_s) begin
                div_cnt_r <= DIV_W'(0);
                bclk_r    <= ~bclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            underrun_r <= frame_start_s & fifo_empty_s;
            // lrck and sdata move only with bclk falling so they are stable at its rise.
            if (fall_evt_s) begin
                bit_cnt_r <= bit_cnt_nxt_s;
                lrck_r    <= (bit_cnt_nxt_s >= SLOT_FIRST);
                sdata_r   <= sdata_nxt_s;
            end
            if (frame_start_s) begin
                word_r <= load_word_s;
            end
        end
    end

    assign sample_ready = sample_ready_r;
    assign bclk         = bclk_r;
    assign lrck         = lrck_r;
    assign sdata        = sdata_r;
    assign underrun     = underrun_r;

endmodule
